// File: rtl/cpu_pkg.sv
// Shared definitions for the four-byte-instruction CPU sequencer.
package cpu_pkg;

   typedef enum logic [3:0] {
      FETCH0    = 4'd0,
      FETCH1    = 4'd1,
      FETCH2    = 4'd2,
      FETCH3    = 4'd3,
      FETCH4    = 4'd4,
      EXEC      = 4'd5,
      WAIT_IO   = 4'd6,
      HALT      = 4'd7,
      STEP_WAIT = 4'd8
   } seq_state_t;

   localparam int OPC_IMM1_BIT = 7;
   localparam int OPC_IMM2_BIT = 6;
   localparam int OPC_COND_BIT = 5;

   localparam logic [2:0] PC_INDEX    = 3'd6;
   localparam logic [2:0] IO_INDEX    = 3'd7;
   localparam logic [7:0] HALT_OPCODE = 8'hFF;

endpackage

// File: rtl/seq_next_pc.sv
// Next program counter select: conditional jump, direct counter write, or pc+4.
module seq_next_pc #(
   parameter logic [2:0] PC_INDEX = 3'd6
) (
   input  logic       i_cond,
   input  logic       i_cond_true,
   input  logic [7:0] i_dest,
   input  logic [7:0] i_alu_result,
   input  logic [7:0] i_pc,
   output logic [7:0] o_next_pc
);

   logic [7:0] w_pc_inc;

   assign w_pc_inc = i_pc + 8'd4;

   always_comb begin
      if (i_cond)
         o_next_pc = i_cond_true ? i_dest : w_pc_inc;
      else if (i_dest[2:0] == PC_INDEX)
         o_next_pc = i_alu_result;
      else
         o_next_pc = w_pc_inc;
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute controller: fetches four instruction bytes, stalls on I/O, strobes execute.
// Optional single-step gating is enabled with CPU_SEQUENCER_SINGLE_STEP_EN.
//
// state     | meaning
// FETCH0    | present pc to ROM
// FETCH1..3 | present pc+k, capture previous byte into OPBUSk
// FETCH4    | capture dest byte, decide halt / stall / execute
// EXEC      | one-cycle commit strobe, pc update
// WAIT_IO   | hold operands until I/O handshakes are satisfied
// HALT      | frozen until reset
// STEP_WAIT | wait for step pulse (single-step build only)
module cpu_sequencer #(
   parameter logic [7:0] RESET_PC    = 8'h00,
   parameter logic [2:0] PC_INDEX    = cpu_pkg::PC_INDEX,
   parameter logic [2:0] IO_INDEX    = cpu_pkg::IO_INDEX,
   parameter logic [7:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
   input  logic       clk,
   input  logic       res,
   output logic [7:0] prog_addr,
   input  logic [7:0] prog_data,
   output logic [7:0] OPBUS1,
   output logic [7:0] OPBUS2,
   output logic [7:0] OPBUS3,
   output logic [7:0] OPBUS4,
   output logic       exec_valid,
   input  logic       cond_true,
   input  logic [7:0] alu_result,
   input  logic       in_valid,
   output logic       IEnable,
   input  logic       out_ready,
   output logic       OEnable,
   output logic [7:0] pc,
   output logic       halted
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
   ,
   input  logic       step
`endif
);

   import cpu_pkg::*;

   seq_state_t r_state;
   seq_state_t w_state_nxt;
   logic [7:0] r_pc;
   logic [7:0] r_op1;
   logic [7:0] r_op2;
   logic [7:0] r_op3;
   logic [7:0] r_op4;
   logic [7:0] w_next_pc;
   logic [2:0] w_dest_idx;
   logic       w_imm1;
   logic       w_imm2;
   logic       w_cond;
   logic       w_need_in;
   logic       w_need_out;
   logic       w_io_ok;

   // In FETCH4 the dest byte is still on prog_data, so the stall decision looks there.
   assign w_dest_idx = (r_state == FETCH4) ? prog_data[2:0] : r_op4[2:0];
   assign w_imm1     = r_op1[OPC_IMM1_BIT];
   assign w_imm2     = r_op1[OPC_IMM2_BIT];
   assign w_cond     = r_op1[OPC_COND_BIT];
   assign w_need_in  = (!w_imm1 && (r_op2[2:0] == IO_INDEX)) ||
                       (!w_imm2 && (r_op3[2:0] == IO_INDEX));
   assign w_need_out = !w_cond && (w_dest_idx == IO_INDEX);
   assign w_io_ok    = (!w_need_in || in_valid) && (!w_need_out || out_ready);

   assign OPBUS1     = r_op1;
   assign OPBUS2     = r_op2;
   assign OPBUS3     = r_op3;
   assign OPBUS4     = r_op4;
   assign pc         = r_pc;
   assign exec_valid = (r_state == EXEC);
   assign IEnable    = (r_state == EXEC) && w_need_in;
   assign OEnable    = (r_state == EXEC) && w_need_out;
   assign halted     = (r_state == HALT);

   always_comb begin
      case (r_state)
         FETCH1:  prog_addr = r_pc + 8'd1;
         FETCH2:  prog_addr = r_pc + 8'd2;
         FETCH3:  prog_addr = r_pc + 8'd3;
         default: prog_addr = r_pc;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FETCH0: w_state_nxt = FETCH1;
         FETCH1: w_state_nxt = FETCH2;
         FETCH2: w_state_nxt = FETCH3;
         FETCH3: w_state_nxt = FETCH4;
         FETCH4: begin
            if (r_op1 == HALT_OPCODE)
               w_state_nxt = HALT;
            else if (!w_io_ok)
               w_state_nxt = WAIT_IO;
            else
               w_state_nxt = EXEC;
         end
         WAIT_IO: begin
            if (w_io_ok)
               w_state_nxt = EXEC;
         end
         EXEC: begin
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
            w_state_nxt = STEP_WAIT;
`else
            w_state_nxt = FETCH0;
`endif
         end
         STEP_WAIT: begin
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
            if (step)
               w_state_nxt = FETCH0;
`else
            w_state_nxt = FETCH0;
`endif
         end
         HALT:    w_state_nxt = HALT;
         default: w_state_nxt = FETCH0;
      endcase
   end

   seq_next_pc #(
      .PC_INDEX (PC_INDEX)
   ) u_next_pc (
      .i_cond       (w_cond),
      .i_cond_true  (cond_true),
      .i_dest       (r_op4),
      .i_alu_result (alu_result),
      .i_pc         (r_pc),
      .o_next_pc    (w_next_pc)
   );

   always_ff @(posedge clk) begin
      if (!res) begin
         r_state <= FETCH0;
         r_pc    <= RESET_PC;
         r_op1   <= 8'h00;
         r_op2   <= 8'h00;
         r_op3   <= 8'h00;
         r_op4   <= 8'h00;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            FETCH1:  r_op1 <= prog_data;
            FETCH2:  r_op2 <= prog_data;
            FETCH3:  r_op3 <= prog_data;
            FETCH4:  r_op4 <= prog_data;
            EXEC:    r_pc  <= w_next_pc;
            default: ;
         endcase
      end
   end

endmodule
